// File: rtl/psg_cmd_writer.sv
// psg_cmd_writer: queues PSG tone/attenuation commands and writes their bytes over a Z80-style memory bus.
module psg_cmd_writer #(
  parameter logic [7:0] PORT_ADDR = 8'h7F,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [1:0]  cmd_chan,
  input  logic [9:0]  cmd_freq,
  input  logic [3:0]  cmd_atten,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        MREQ_N,
  output logic        WR_N,
  output logic        busy,
  output logic        cmd_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, GAP = 2'd3;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [15:0]   tmr;
  logic          pend;
  logic [7:0]    byte1;
  logic          strobe_n;
  logic [16:0]   head;
  logic          accept, push, pop;
  logic [7:0]    head_byte0;
  assign head = mem[rd_ptr];
  assign cmd_ready = count != (AW+1)'(FIFO_DEPTH);
  assign accept = cmd_valid && cmd_ready;
  assign push = accept && cmd_chan != 2'd3;
  assign pop = state == IDLE && count != '0;
  assign head_byte0 = head[16] ? {1'b1, head[15:14], 1'b1, head[3:0]} : {1'b1, head[15:14], 1'b0, head[7:4]};
  assign busy = count != '0 || state != IDLE;
  // one register drives both strobes so they can never skew apart
  assign MREQ_N = strobe_n;
  assign WR_N = strobe_n;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_type, cmd_chan, cmd_freq, cmd_atten};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      state <= IDLE;
      tmr <= '0;
      pend <= 1'b0;
      byte1 <= '0;
      strobe_n <= 1'b1;
      addr <= '0;
      data <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept && cmd_chan == 2'd3;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          state <= SETUP;
          addr <= {8'h00, PORT_ADDR};
          data <= head_byte0;
          pend <= !head[16];
          byte1 <= {2'b00, head[13:8]};
        end
        SETUP: begin
          state <= STROBE;
          strobe_n <= 1'b0;
          tmr <= '0;
        end
        STROBE: if (tmr == 16'(STROBE_CYCLES - 1)) begin
          state <= GAP;
          strobe_n <= 1'b1;
          tmr <= '0;
        end else tmr <= tmr + 1'b1;
        default: if (tmr == 16'(GAP_CYCLES - 1)) begin
          state <= pend ? SETUP : IDLE;
          if (pend) data <= byte1;
          pend <= 1'b0;
        end else tmr <= tmr + 1'b1;
      endcase
    end
endmodule
